// File: rtl/pipe_buf_pkg.sv
// Shared types and constants for the pipe_buf elastic buffer and its stages.
package pipe_buf_pkg;

  localparam int MAX_STAGES = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  function automatic logic [1:0] state_count(stage_state_e s);
    case (s)
      ONE:     state_count = 2'd1;
      TWO:     state_count = 2'd2;
      default: state_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_buf_stage.sv
// One elastic stage: main + skid register, ready registered so out_ready never reaches in_ready.
module pipe_buf_stage
  import pipe_buf_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic             push, pop;

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign count     = state_count(state_q);

  assign push = in_valid & rdy_q;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // valid state only; payload registers keep their contents
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          main_d  = in_data;
          state_d = ONE;
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            skid_d  = in_data;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
    rdy_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: rtl/pipe_buf.sv
// Chain of STAGES elastic stages; occupancy is the sum of the per-stage entry counts.
module pipe_buf
  import pipe_buf_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

  localparam int OCC_W = $clog2(2*STAGES+1);

  logic [STAGES:0]              vld_chain;
  logic [STAGES:0]              rdy_chain;
  logic [STAGES:0][WIDTH-1:0]   dat_chain;
  logic [STAGES-1:0][1:0]       stage_cnt;

  assign vld_chain[0]      = in_valid;
  assign dat_chain[0]      = in_data;
  assign in_ready          = rdy_chain[0];
  assign rdy_chain[STAGES] = out_ready;
  assign out_valid         = vld_chain[STAGES];
  assign out_data          = dat_chain[STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pipe_buf_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (vld_chain[i]),
      .in_ready  (rdy_chain[i]),
      .in_data   (dat_chain[i]),
      .out_valid (vld_chain[i+1]),
      .out_ready (rdy_chain[i+1]),
      .out_data  (dat_chain[i+1]),
      .count     (stage_cnt[i])
    );
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(stage_cnt[i]);
    end
  end

endmodule

// File: tb/tb_pipe_buf.sv
// Directed and randomised checks of pipe_buf with WIDTH=8, STAGES=2.
module tb_pipe_buf;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int OCC_W  = $clog2(2*STAGES+1);

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             flush     = 1'b0;
  logic             in_valid  = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  int n_assert = 0;
  int n_fail   = 0;
  int q[$];

  always #5 clk = ~clk;

  pipe_buf #(
    .WIDTH       (WIDTH),
    .STAGES      (STAGES),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset asserted mid-cycle
    #12 reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in_ready", in_ready, 0);
    tick(); tick();
    chk("rst_in_ready_held", in_ready, 0);
    reset = 1'b1;
    chk("rst_release_pre_edge", in_ready, 0);
    tick();
    chk("rst_in_ready_up", in_ready, 1);
    chk("rst_out_valid_after", out_valid, 0);
    chk("rst_occ_after", occupancy, 0);

    // streaming 0x11, 0x22, 0x33
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    tick();
    chk("str_c1_valid", out_valid, 0);
    chk("str_c1_occ", occupancy, 1);
    in_data = 8'h22;
    tick();
    chk("str_c2_valid", out_valid, 1);
    chk("str_c2_data", out_data, 8'h11);
    chk("str_c2_occ", occupancy, 2);
    in_data = 8'h33;
    tick();
    chk("str_c3_valid", out_valid, 1);
    chk("str_c3_data", out_data, 8'h22);
    chk("str_c3_in_ready", in_ready, 1);
    in_valid = 1'b0;
    tick();
    chk("str_c4_valid", out_valid, 1);
    chk("str_c4_data", out_data, 8'h33);
    chk("str_c4_occ", occupancy, 1);
    tick();
    chk("str_c5_valid", out_valid, 0);
    chk("str_c5_hold", out_data, 8'h33);
    chk("str_c5_occ", occupancy, 0);

    // backpressure: only four of five offered entries fit
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_data = 8'(k);
      chk("bp_in_ready_open", in_ready, 1);
      tick();
    end
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_occ", occupancy, 4);
    chk("bp_data", out_data, 8'h01);
    in_data = 8'h05;
    tick();
    chk("bp_occ_stuck", occupancy, 4);
    chk("bp_data_stable", out_data, 8'h01);
    chk("bp_valid", out_valid, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("bp_drain_valid", out_valid, 1);
      chk("bp_drain_data", out_data, 32'(k));
      tick();
    end
    chk("bp_drained_valid", out_valid, 0);
    chk("bp_drained_occ", occupancy, 0);

    // flush at occupancy 3 with a simultaneous push
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 8'hA1; tick();
    in_data = 8'hA2; tick();
    in_data = 8'hA3; tick();
    chk("fl_occ_pre", occupancy, 3);
    flush   = 1'b1;
    in_data = 8'hAA;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_occ", occupancy, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_data_kept", out_data, 8'hA1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fl_no_output", out_valid, 0);
    end

    // push and pop on the same edge with one entry held
    in_valid = 1'b1;
    in_data  = 8'h40;
    tick();
    in_valid = 1'b0;
    tick();
    chk("sim_pre_occ", occupancy, 1);
    chk("sim_pre_data", out_data, 8'h40);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    chk("sim_occ", occupancy, 1);
    tick();
    chk("sim_next_valid", out_valid, 1);
    chk("sim_next_data", out_data, 8'h5A);
    tick();
    chk("sim_empty", occupancy, 0);

    // random valid/ready against a queue model
    for (int c = 0; c < 1000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_spurious", out_valid, 0);
        else chk("rnd_data", out_data, 32'(q.pop_front()));
      end
      if (in_valid && in_ready) q.push_back(int'(in_data));
      tick();
      chk("rnd_occ", occupancy, 32'(q.size()));
      chk("rnd_occ_le4", occupancy <= 4, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        if (q.size() == 0) chk("rnd_drain_spurious", out_valid, 0);
        else chk("rnd_drain_data", out_data, 32'(q.pop_front()));
      end
      tick();
    end
    chk("rnd_left", 32'(q.size()), 0);
    chk("rnd_final_occ", occupancy, 0);

    // reset in the middle of traffic
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("mrst_occ", occupancy, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 8'h00);
    chk("mrst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("mrst_in_ready_up", in_ready, 1);
    chk("mrst_after_valid", out_valid, 0);
    chk("mrst_after_occ", occupancy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_buf.md
PIPE_BUF -- requirements
Module: pipe_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the payload width in bits.
REQ-002 The block SHALL have parameter STAGES, default 1, giving the number of chained stages (legal range 1..8).
REQ-003 The block SHALL have parameter RESET_VALUE, default 0 (WIDTH bits), giving the data-register reset contents.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-006 The block SHALL have port flush, input, 1 bit, a synchronous discard of all held entries.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning the upstream offers in_data.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts in_data this cycle.
REQ-009 The block SHALL have port in_data, input, WIDTH bits, the upstream payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning out_data holds a valid entry.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning downstream consumes out_data this cycle.
REQ-012 The block SHALL have port out_data, output, WIDTH bits, the oldest held payload.
REQ-013 The block SHALL have port occupancy, output, $clog2(2*STAGES+1) bits, the number of valid entries held.

Function
REQ-014 A transfer SHALL occur on a rising edge exactly when valid and ready are both 1 on that side.
REQ-015 Each stage SHALL hold a main register and a skid register, giving 2*STAGES entries in total.
REQ-016 Each stage SHALL implement states EMPTY, ONE (main valid) and TWO (main and skid valid).
REQ-017 Stage transitions SHALL be: EMPTY->ONE on push; ONE->ONE on push with pop; ONE->EMPTY on pop without push; ONE->TWO on push without pop; TWO->ONE on pop.
REQ-018 Stage in_ready SHALL be registered and equal to (state != TWO), with no combinational path from out_ready to in_ready.
REQ-019 In state TWO a pop SHALL move skid into main in the same edge.
REQ-020 Data order SHALL be strict FIFO.
REQ-021 Latency SHALL be STAGES cycles from acceptance into an empty block to out_valid=1.
REQ-022 Sustained throughput SHALL be one transfer per cycle when out_ready is held at 1.
REQ-023 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 out_data SHALL hold its last value while out_valid=0.
REQ-025 occupancy SHALL equal the sum of valid entries over all stages, updated on the same edge as the valid bits.
REQ-026 When flush=1 at an edge, all stages SHALL enter EMPTY and occupancy SHALL become 0, taking priority over a simultaneous push or pop.
REQ-027 An input offered during a flush cycle SHALL be discarded, and an output popped during a flush cycle SHALL count as consumed.
REQ-028 Flush SHALL clear valid bits only and SHALL leave data registers unchanged.

Reset
REQ-029 Asserting reset (low) SHALL immediately force all stages to EMPTY, set out_valid=0, set occupancy=0 and load RESET_VALUE into every data register, irrespective of clk.
REQ-030 While reset is low, in_ready SHALL be 0.
REQ-031 in_ready SHALL become 1 on the first rising edge after reset deasserts.
REQ-032 A reset arriving mid-transfer SHALL discard all entries, with no partial entry surviving.

Structure
REQ-033 A shared package SHALL hold the stage-state enum (EMPTY, ONE, TWO) and the constant MAX_STAGES=8.
REQ-034 The per-stage logic SHALL be a sub-module pipe_buf_stage, instantiated STAGES times by a generate loop.
REQ-035 Each stage SHALL export its local count, and pipe_buf SHALL sum the local counts into occupancy.

Verification
REQ-036 Reset check: WIDTH=8, STAGES=2, reset low mid-cycle -> out_valid=0, occupancy=0 and out_data=0x00 immediately; in_ready=1 one edge after release.
REQ-037 Streaming check: push 0x11, 0x22, 0x33 on back-to-back cycles with out_ready=1 -> out_valid rises 2 cycles after the first push and 0x11, 0x22, 0x33 appear on consecutive cycles.
REQ-038 Backpressure check: out_ready=0 while pushing 0x01..0x05 -> exactly 4 accepted, in_ready=0, occupancy=4, out_data stable at 0x01; then out_ready=1 -> 0x01..0x04 drain in order.
REQ-039 Flush check: flush=1 at occupancy=3 with a simultaneous push of 0xAA -> occupancy=0 and out_valid=0 next cycle, and 0xAA never appears at the output.
REQ-040 Simultaneous check: in stage state ONE, push 0x5A with pop on the same edge -> occupancy unchanged and 0x5A becomes the next output.
REQ-041 Randomised check: valid/ready toggling at 50% for 1000 cycles -> a scoreboard shows no loss, duplication or reordering, and occupancy never exceeds 4.
